// File: rtl/mgt_01_fp_regfile_mp.sv
// mgt_01_fp_regfile_mp: multi-port FP register file with per-register pending bits.
// After reset a sequencer zeroes every entry before the file reports ready.
// Optional macro FRF_BYPASS_EN: same-cycle write-to-read forwarding in RUN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | zeroing reg[clr_cnt] each cycle, ports ignored, reads invalid
// ST_RUN   | normal operation: writes, reservations, reads
module mgt_01_fp_regfile_mp #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int N_RD   = 3,
  parameter int N_WR   = 2,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [N_RD*DATA_W-1:0]   rd_data_o,
  output logic [N_RD-1:0]          rd_valid_o,
  input  logic [N_WR-1:0]          wr_en_i,
  input  logic [N_WR*ADDR_W-1:0]   wr_addr_i,
  input  logic [N_WR*DATA_W-1:0]   wr_data_i,
  input  logic                     rsv_en_i,
  input  logic [ADDR_W-1:0]        rsv_addr_i,
  output logic                     ready_o,
  output logic [DEPTH-1:0]         pend_o
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DEPTH-1:0]    pend_q, pend_d;
  logic [DEPTH-1:0]    wr_hit, rsv_hit;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // State, clear counter and pending bits; reset discards everything in flight
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      pend_q    <= pend_d;
    end
  end

  // Next state: walk the clear counter through every entry, then run
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d = ST_RUN;
      end
    end
  end

  // Outputs: ready is a decode of the registered state, so it is glitch-free
  always_comb begin
    ready_o = (state_q == ST_RUN);
    pend_o  = pend_q;
  end

  // One-hot decode of write and reservation targets
  always_comb begin
    wr_hit  = '0;
    rsv_hit = '0;
    for (int w = 0; w < N_WR; w++) begin
      if (wr_en_i[w]) wr_hit[wr_addr_i[w*ADDR_W +: ADDR_W]] = 1'b1;
    end
    if (rsv_en_i) rsv_hit[rsv_addr_i] = 1'b1;
  end

  // Pending update: a reservation outranks a same-cycle writeback (it is the newer op)
  always_comb begin
    pend_d = pend_q;
    if (state_q == ST_RUN) begin
      pend_d = (pend_q & ~wr_hit) | rsv_hit;
    end
  end

  // Array writes: clear sweep, or port writes where the highest port index lands last
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      if (state_q == ST_CLEAR) begin
        mem_q[clr_cnt_q] <= '0;
      end else begin
        for (int w = 0; w < N_WR; w++) begin
          if (wr_en_i[w]) begin
            mem_q[wr_addr_i[w*ADDR_W +: ADDR_W]] <= wr_data_i[w*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  for (genvar gp = 0; gp < N_RD; gp++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] data;
    logic              valid;

    assign ra = rd_addr_i[gp*ADDR_W +: ADDR_W];

    // Combinational read; optional forwarding from the highest matching write port
    always_comb begin
      data  = '0;
      valid = 1'b0;
      if (state_q == ST_RUN) begin
        data  = mem_q[ra];
        valid = !pend_q[ra];
`ifdef FRF_BYPASS_EN
        for (int w = 0; w < N_WR; w++) begin
          if (wr_en_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] == ra)) begin
            data  = wr_data_i[w*DATA_W +: DATA_W];
            valid = !(rsv_en_i && (rsv_addr_i == ra));
          end
        end
`endif
      end
    end

    assign rd_data_o[gp*DATA_W +: DATA_W] = data;
    assign rd_valid_o[gp]                 = valid;
  end

endmodule

// File: tb/tb_mgt_01_fp_regfile_mp.sv
// Directed bench for mgt_01_fp_regfile_mp (default parameters: 32x32, 3 read, 2 write ports).
module tb_mgt_01_fp_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] rd_addr;
  logic [95:0] rd_data;
  logic [2:0]  rd_valid;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        ready;
  logic [31:0] pend;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  mgt_01_fp_regfile_mp dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .rd_valid_o(rd_valid),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rsv_en_i  (rsv_en),
    .rsv_addr_i(rsv_addr),
    .ready_o   (ready),
    .pend_o    (pend)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] rdp(input int p);
    return {rd_valid[p], rd_data[p*32 +: 32]};
  endfunction

  task automatic setrd(input int p, input logic [4:0] a);
    rd_addr[p*5 +: 5] = a;
  endtask

  task automatic setwr(input int w, input logic [4:0] a, input logic [31:0] d);
    wr_en[w]          = 1'b1;
    wr_addr[w*5 +: 5] = a;
    wr_data[w*32 +: 32] = d;
  endtask

  // Counts rising edges until ready is seen at a falling edge; gives up at 100
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (cnt < 100) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (ready) break;
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;

    // 1: reset and clear sequence
    step; step;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_pend", 64'(pend), 64'd0);
    rst_n = 1'b1;
    #1 chk("clear_ready0", 64'(ready), 64'd0);
    chk("clear_rdvalid", 64'(rd_valid), 64'd0);
    wait_ready(n);
    chk("clear_len", 64'(n), 64'd32);
    for (int a = 0; a < 32; a++) begin
      setrd(a % 3, 5'(a));
      #1 chk($sformatf("init_rd%0d", a), 64'(rdp(a % 3)), {31'd0, 1'b1, 32'h0});
    end

    // 2: write then read
    @(negedge clk);
    setwr(0, 5'd5, 32'h3F80_0000);
    setrd(0, 5'd5);
`ifdef FRF_BYPASS_EN
    #1 chk("raw_same", 64'(rdp(0)), {31'd0, 1'b1, 32'h3F80_0000});
`else
    #1 chk("raw_same", 64'(rdp(0)), {31'd0, 1'b1, 32'h0});
`endif
    step;
    wr_en = '0;
    #1 chk("raw_next", 64'(rdp(0)), {31'd0, 1'b1, 32'h3F80_0000});

    // 3: port conflict, higher index wins
    @(negedge clk);
    setwr(0, 5'd7, 32'h1111_1111);
    setwr(1, 5'd7, 32'h2222_2222);
    setrd(1, 5'd7);
`ifdef FRF_BYPASS_EN
    #1 chk("conf_same", 64'(rdp(1)), {31'd0, 1'b1, 32'h2222_2222});
`endif
    step;
    wr_en = '0;
    #1 chk("conf_next", 64'(rdp(1)), {31'd0, 1'b1, 32'h2222_2222});

    // 4: scoreboard
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 5'd9;
    step;
    rsv_en = 1'b0;
    setrd(2, 5'd9);
    #1 chk("rsv_pend", 64'(pend), 64'h0000_0200);
    chk("rsv_rd", 64'(rdp(2)), {31'd0, 1'b0, 32'h0});
    setwr(1, 5'd9, 32'h4000_0000);
`ifdef FRF_BYPASS_EN
    #1 chk("wb_same", 64'(rdp(2)), {31'd0, 1'b1, 32'h4000_0000});
`else
    #1 chk("wb_same", 64'(rdp(2)), {31'd0, 1'b0, 32'h0});
`endif
    step;
    wr_en = '0;
    #1 chk("wb_pend", 64'(pend), 64'd0);
    chk("wb_rd", 64'(rdp(2)), {31'd0, 1'b1, 32'h4000_0000});
    setwr(0, 5'd9, 32'h0000_1234);
    rsv_en = 1'b1; rsv_addr = 5'd9;
`ifdef FRF_BYPASS_EN
    #1 chk("rsvwb_same", 64'(rdp(2)), {31'd0, 1'b0, 32'h0000_1234});
`endif
    step;
    wr_en = '0; rsv_en = 1'b0;
    #1 chk("rsvwb_pend", 64'(pend), 64'h0000_0200);
    chk("rsvwb_rd", 64'(rdp(2)), {31'd0, 1'b0, 32'h0000_1234});

    // 5: reset mid-operation
    @(negedge clk);
    setwr(0, 5'd3, 32'hDEAD_BEEF);
    step;
    wr_en = '0;
    rsv_en = 1'b1; rsv_addr = 5'd4;
    step;
    rsv_en = 1'b0;
    setrd(0, 5'd3);
    #1 chk("mid_pend", 64'(pend), 64'h0000_0210);
    chk("mid_rd3", 64'(rdp(0)), {31'd0, 1'b1, 32'hDEAD_BEEF});
    rst_n = 1'b0;
    setwr(1, 5'd3, 32'hCAFE_F00D);
    step;
    rst_n = 1'b1; wr_en = '0;
    #1 chk("mid_rst_pend", 64'(pend), 64'd0);
    chk("mid_rst_ready", 64'(ready), 64'd0);
    wait_ready(n);
    chk("mid_clear_len", 64'(n), 64'd32);
    setrd(0, 5'd3); setrd(1, 5'd4); setrd(2, 5'd9);
    #1 chk("mid_rd3_zero", 64'(rdp(0)), {31'd0, 1'b1, 32'h0});
    chk("mid_rd4", 64'(rdp(1)), {31'd0, 1'b1, 32'h0});
    chk("mid_rd9", 64'(rdp(2)), {31'd0, 1'b1, 32'h0});

    // 6: traffic during CLEAR is ignored
    @(negedge clk);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    setwr(0, 5'd10, 32'hAAAA_AAAA);
    setwr(1, 5'd11, 32'h5555_5555);
    rsv_en = 1'b1; rsv_addr = 5'd12;
    setrd(0, 5'd10);
    for (int i = 0; i < 12; i++) begin
      step;
      setwr(0, 5'(i), 32'hAAAA_AAAA);
    end
    #1 chk("clr_rd_blocked", 64'(rdp(0)), {31'd0, 1'b0, 32'h0});
    chk("clr_pend", 64'(pend), 64'd0);
    wait_ready(n);
    chk("clr6_len", 64'(n), 64'd20);
    wr_en = '0; rsv_en = 1'b0;
    #1 chk("clr6_pend", 64'(pend), 64'd0);
    for (int a = 0; a < 32; a++) begin
      setrd(a % 3, 5'(a));
      #1 chk($sformatf("clr6_rd%0d", a), 64'(rdp(a % 3)), {31'd0, 1'b1, 32'h0});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
